// File: rtl/sel_nw_rr_if.sv
// rtl/sel_nw_rr_if.sv - channel/consumer bundle for the N-channel registered selector
//
// Purpose: groups the producer-side channel signals and the consumer-side output
// stream of sel_nw_rr into one interface.
//   in_data  N*W  channel data, channel k in bits [k*W +: W]
//   req      N    per-channel request
//   gnt      N    one-hot grant (combinational, from the selector)
//   mode     1    0 = direct select, 1 = round-robin
//   sel      SW   channel index for direct mode
//   out_data W    registered selected word
//   out_ch   SW   channel index of the held word
//   out_vld  1    held word is valid
//   out_rdy  1    consumer accepts the held word this cycle
//   out_par  1    even parity of out_data (only with SEL_PARITY_EN)
// Modports: master = producers/consumer side, slave = selector.
// Optional feature macro: SEL_PARITY_EN.
interface sel_nw_rr_if #(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int SW = 2
);
   logic [N*W-1:0] in_data;
   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_ch;
   logic           out_vld;
   logic           out_rdy;
`ifdef SEL_PARITY_EN
   logic           out_par;

   modport master (
      output in_data, req, mode, sel, out_rdy,
      input  gnt, out_data, out_ch, out_vld, out_par
   );

   modport slave (
      input  in_data, req, mode, sel, out_rdy,
      output gnt, out_data, out_ch, out_vld, out_par
   );
`else
   modport master (
      output in_data, req, mode, sel, out_rdy,
      input  gnt, out_data, out_ch, out_vld
   );

   modport slave (
      input  in_data, req, mode, sel, out_rdy,
      output gnt, out_data, out_ch, out_vld
   );
`endif
endinterface

// File: rtl/sel_nw_rr.sv
// rtl/sel_nw_rr.sv - N-channel W-bit registered selector with direct and round-robin modes
//
// Purpose: picks one requesting channel per cycle (direct via sel, or round-robin
// from an internal pointer), grants it, and registers its word into a one-deep
// output stage with valid/ready back-pressure.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-high reset
//   bus_io  sel_nw_rr_if.slave (channel data/requests/grants, mode/sel, output stream)
// Optional feature macro: SEL_PARITY_EN adds out_par = ^out_data, registered with it.
module sel_nw_rr #(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   sel_nw_rr_if.slave  bus_io
);

   logic [W-1:0]  out_q,    out_d;
   logic [SW-1:0] out_ch_q, out_ch_d;
   logic          out_vld_q, out_vld_d;
   logic [SW-1:0] ptr_q,    ptr_d;
`ifdef SEL_PARITY_EN
   logic          out_par_q, out_par_d;
`endif

   logic          load_ok;
   logic          cand_vld;
   logic [SW-1:0] cand_ch;
   logic [W-1:0]  cand_data;
   logic [N-1:0]  gnt;
   logic [SW:0]   rr_sum;
   logic [SW-1:0] rr_idx;

   assign load_ok = ~out_vld_q | bus_io.out_rdy;

   // Candidate search. In round-robin the scan starts at ptr_q and wraps at N
   // (not at 2^SW), so the index is reduced modulo N by a single subtract.
   always_comb begin
      cand_vld = 1'b0;
      cand_ch  = '0;
      rr_sum   = '0;
      rr_idx   = '0;
      if (!bus_io.mode) begin
         // sel >= N never matches any k, so it yields no candidate.
         for (int k = 0; k < N; k++) begin
            if (bus_io.sel == SW'(k) && bus_io.req[k]) begin
               cand_vld = 1'b1;
               cand_ch  = SW'(k);
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            rr_sum = {1'b0, ptr_q} + (SW+1)'(k);
            if (rr_sum >= (SW+1)'(N)) begin
               rr_sum = rr_sum - (SW+1)'(N);
            end
            rr_idx = rr_sum[SW-1:0];
            if (!cand_vld && bus_io.req[rr_idx]) begin
               cand_vld = 1'b1;
               cand_ch  = rr_idx;
            end
         end
      end
   end

   always_comb begin
      cand_data = '0;
      for (int k = 0; k < N; k++) begin
         if (cand_ch == SW'(k)) begin
            cand_data = bus_io.in_data[k*W +: W];
         end
      end
   end

   // Grant is forced low during reset so no word is consumed upstream while
   // the output stage is being cleared.
   always_comb begin
      gnt = '0;
      if (!rst_i && load_ok && cand_vld) begin
         for (int k = 0; k < N; k++) begin
            if (cand_ch == SW'(k)) begin
               gnt[k] = 1'b1;
            end
         end
      end
   end

   assign bus_io.gnt = gnt;

   always_comb begin
      out_d     = out_q;
      out_ch_d  = out_ch_q;
      out_vld_d = out_vld_q;
      ptr_d     = ptr_q;
      if (gnt != '0) begin
         out_d     = cand_data;
         out_ch_d  = cand_ch;
         out_vld_d = 1'b1;
         if (bus_io.mode) begin
            ptr_d = (cand_ch == SW'(N-1)) ? '0 : cand_ch + SW'(1);
         end
      end else if (load_ok) begin
         // Slot is free (or being emptied) and nothing to load: drain.
         out_vld_d = 1'b0;
      end
   end

`ifdef SEL_PARITY_EN
   assign out_par_d = ^out_d;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q     <= '0;
         out_ch_q  <= '0;
         out_vld_q <= 1'b0;
         ptr_q     <= '0;
`ifdef SEL_PARITY_EN
         out_par_q <= 1'b0;
`endif
      end else begin
         out_q     <= out_d;
         out_ch_q  <= out_ch_d;
         out_vld_q <= out_vld_d;
         ptr_q     <= ptr_d;
`ifdef SEL_PARITY_EN
         out_par_q <= out_par_d;
`endif
      end
   end

   assign bus_io.out_data = out_q;
   assign bus_io.out_ch   = out_ch_q;
   assign bus_io.out_vld  = out_vld_q;
`ifdef SEL_PARITY_EN
   assign bus_io.out_par  = out_par_q;
`endif

endmodule
